// File: rtl/mult32_pkg.sv
// Shared datapath definitions for the DaVinci multiplier.
package mult32_pkg;
    localparam int DATA_WIDTH       = 32;
    localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;
    localparam int PRODUCT_WIDTH    = 2 * DATA_WIDTH;
endpackage

// File: rtl/mult32_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the upper half, then an arithmetic shift of {upper, Q, q-1}.
module booth_step #(
    parameter int DATA_WIDTH = mult32_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_upper,
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic                  i_qm1,
    input  logic [DATA_WIDTH-1:0] i_mcand,
    output logic [DATA_WIDTH-1:0] o_upper,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_qm1
);
    import mult32_pkg::*;

    logic [DATA_WIDTH:0] w_upper_ext;
    logic [DATA_WIDTH:0] w_mcand_ext;
    logic [DATA_WIDTH:0] w_sum;

    // One guard bit keeps the sum exact when the multiplicand is the most negative value.
    always_comb begin
        w_upper_ext = {i_upper[DATA_WIDTH-1], i_upper};
        w_mcand_ext = {i_mcand[DATA_WIDTH-1], i_mcand};
        case ({i_q[0], i_qm1})
            2'b01:   w_sum = w_upper_ext + w_mcand_ext;
            2'b10:   w_sum = w_upper_ext - w_mcand_ext;
            default: w_sum = w_upper_ext;
        endcase
    end

    assign o_upper = w_sum[DATA_WIDTH:1];
    assign o_q     = {w_sum[0], i_q[DATA_WIDTH-1:1]};
    assign o_qm1   = i_q[0];
endmodule

// File: rtl/mult32.sv
// Iterative signed multiplier: one Booth step per cycle, 32 steps per product,
// start/done handshake, registered HI/LO result.
module mult32 #(
    parameter int DATA_WIDTH = mult32_pkg::DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  BUSY,
    output logic                  DONE
);
    import mult32_pkg::*;

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_upper;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_qm1;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_upper_n;
    logic [DATA_WIDTH-1:0] w_q_n;
    logic                  w_qm1_n;

    booth_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_upper (r_upper),
        .i_q     (r_q),
        .i_qm1   (r_qm1),
        .i_mcand (r_mcand),
        .o_upper (w_upper_n),
        .o_q     (w_q_n),
        .o_qm1   (w_qm1_n)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = START;
                if (START) w_state_next = RUN;
            end
            RUN: begin
                w_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));
                if (w_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_upper <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_accept) begin
                r_mcand <= A;
                r_upper <= '0;
                r_q     <= B;
                r_qm1   <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_upper <= w_upper_n;
                r_q     <= w_q_n;
                r_qm1   <= w_qm1_n;
                r_cnt   <= r_cnt + 1'b1;
            end
            // The final step's result goes straight to HI/LO on the completing edge.
            if (w_last) begin
                r_hi <= w_upper_n;
                r_lo <= w_q_n;
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign BUSY = (r_state == RUN);
    assign DONE = r_done;
endmodule

// File: tb/tb_mult32.sv
// Randomised and directed checks of mult32 against a plain 64-bit signed product.
module tb_mult32;
    logic        CLK;
    logic        RST;
    logic        START;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        BUSY;
    logic        DONE;

    int          n_checks;
    int          n_errors;
    logic [63:0] last_prod;

    mult32 dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation from START to DONE; optionally disturb A/B and pulse START while busy.
    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit perturb, input bit verbose);
        int          cycles;
        logic [63:0] exp;
        exp = ref_prod(a, b);
        @(negedge CLK);
        A = a; B = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        cycles = 0;
        while (!DONE && cycles < 40) begin
            if (perturb) begin
                A = $urandom; B = $urandom;
                if (cycles == 5) START = 1'b1;
                if (cycles == 6) START = 1'b0;
            end
            if (cycles == 16) check({tag, "_hold"}, {HI, LO}, last_prod);
            @(posedge CLK); #1;
            cycles++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'd32);
        check({tag, "_prod"}, {HI, LO}, exp);
        if (verbose)
            $display("op %s: A=%h B=%h -> HI=%h LO=%h cycles=%0d", tag, a, b, HI, LO, cycles);
        last_prod = exp;
        if (perturb) begin
            @(posedge CLK); #1;
            check({tag, "_no_queue"}, {63'd0, BUSY}, 64'd0);
        end
    endtask

    logic [31:0] pa [5];
    logic [31:0] pb [5];
    int          cyc;
    int          bad;

    initial begin
        n_checks = 0; n_errors = 0; last_prod = '0;
        RST = 1'b0; START = 1'b0; A = '0; B = '0;
        #12;
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_flags", {62'd0, BUSY, DONE}, 64'd0);
        @(negedge CLK); RST = 1'b1;

        bad = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) bad++;
        end
        check("idle_no_done", 64'(bad), 64'd0);

        do_mult("p5xm7",   32'd5,          32'hFFFF_FFF9, 1'b0, 1'b1);
        do_mult("p1xm1",   32'd1,          32'hFFFF_FFFF, 1'b0, 1'b1);
        do_mult("p8xp7",   32'd8,          32'd7,         1'b1, 1'b1);
        do_mult("m2xm3",   32'hFFFF_FFFE,  32'hFFFF_FFFD, 1'b0, 1'b1);
        do_mult("minxmin", 32'h8000_0000,  32'h8000_0000, 1'b1, 1'b1);
        do_mult("minxm1",  32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 1'b1);
        do_mult("zerox1",  32'd0,          32'd1,         1'b1, 1'b1);
        check("spec_minxmin", ref_prod(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);

        // Reset in the middle of a run aborts it and clears the outputs at once.
        do_mult("pre_rst", 32'd5, 32'hFFFF_FFF9, 1'b0, 1'b0);
        @(negedge CLK); A = 32'd123; B = 32'd456; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        repeat (10) @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        check("midrst_hilo", {HI, LO}, 64'd0);
        check("midrst_flags", {62'd0, BUSY, DONE}, 64'd0);
        last_prod = '0;
        @(negedge CLK); RST = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE || BUSY || HI != 0 || LO != 0) bad++;
        end
        check("post_rst_quiet", 64'(bad), 64'd0);

        // START held high: one result every 33 cycles, operands sampled at each accept.
        for (int i = 0; i < 5; i++) begin
            pa[i] = $urandom; pb[i] = $urandom;
        end
        @(negedge CLK); A = pa[0]; B = pb[0]; START = 1'b1;
        @(posedge CLK); #1;
        A = pa[1]; B = pb[1];
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            do begin
                @(posedge CLK); #1;
                cyc++;
                if (cyc == 1 && i > 0) begin
                    A = pa[i+1]; B = pb[i+1];
                end
            end while (!DONE && cyc < 50);
            if (i == 3) START = 1'b0;
            check($sformatf("b2b%0d_gap", i), 64'(cyc), (i == 0) ? 64'd32 : 64'd33);
            check($sformatf("b2b%0d_prod", i), {HI, LO}, ref_prod(pa[i], pb[i]));
            $display("b2b %0d: A=%h B=%h -> HI=%h LO=%h gap=%0d", i, pa[i], pb[i], HI, LO, cyc);
            cyc = 0;
        end
        last_prod = ref_prod(pa[3], pb[3]);
        @(posedge CLK); #1;
        check("b2b_stop", {63'd0, BUSY}, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'h8000_0000;
                2: ra = 32'h7FFF_FFFF;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_mult($sformatf("rnd%0d", i), ra, rb, ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
